nivel2_timer: RTL and testbench

- BCD countdown timer (MM:SS) for the microwave controller.
- Loaded digit-by-digit from the keypad while idle. Counts down one second per prescaled tick while the magnetron runs.
- Sits in a loop with the magnetron control stage: consumes `mag_on` and produces `timer_done`, which the control stage uses to reset its latch.
- Also drives the digits shown on the display.

---
 rtl/nivel2_timer.sv | 107 ++++++++++
 tb/tb_nivel2_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nivel2_timer.sv
// nivel2_timer: BCD MM:SS countdown timer for the microwave controller.
// Digits are entered from the keypad while the magnetron is off and count
// down one second per prescaled tick while it runs. timer_done is a plain
// zero-decode of the stored digits and closes the loop with the magnetron
// control stage, which uses it to drop its run latch.
module nivel2_timer #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       mag_on,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       timer_done
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 32'd1);
    localparam logic [CNT_W-1:0] PRESC_ZERO = '0;
    localparam logic [CNT_W-1:0] PRESC_ONE  = CNT_W'(1);

    // One-second decrement of a packed {mt,mu,st,su} BCD time with borrow
    // through the digit chain; 00:00 is a fixed point (no wrap). Seconds
    // tens are not range-checked, so an entered 0:75 simply counts 75, 74...
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0]  mt;
        logic [3:0]  mu;
        logic [3:0]  st;
        logic [3:0]  su;
        logic [15:0] r;
        {mt, mu, st, su} = t;
        r = t;
        if (su != 4'd0) begin
            r = {mt, mu, st, su - 4'd1};
        end else if (st != 4'd0) begin
            r = {mt, mu, st - 4'd1, 4'd9};
        end else if (mu != 4'd0) begin
            r = {mt, mu - 4'd1, 4'd5, 4'd9};
        end else if (mt != 4'd0) begin
            r = {mt - 4'd1, 4'd9, 4'd5, 4'd9};
        end else begin
            r = t;
        end
        return r;
    endfunction

    logic [15:0]      digits_r;
    logic [15:0]      digits_nxt_s;
    logic [CNT_W-1:0] presc_r;
    logic [CNT_W-1:0] presc_nxt_s;
    logic             tick_s;
    logic             key_ok_s;

    assign tick_s   = mag_on && (presc_r == PRESC_LAST);
    assign key_ok_s = key_valid && !mag_on && (key_digit <= 4'd9);

    // Prescaler next value: clear > idle hold at zero > wrap on tick > count.
    always_comb begin
        presc_nxt_s = presc_r;
        if (!clearn) begin
            presc_nxt_s = PRESC_ZERO;
        end else if (!mag_on) begin
            presc_nxt_s = PRESC_ZERO;
        end else if (tick_s) begin
            presc_nxt_s = PRESC_ZERO;
        end else begin
            presc_nxt_s = presc_r + PRESC_ONE;
        end
    end

    // Digit next value: clear > keypad shift-in > countdown tick > hold.
    always_comb begin
        digits_nxt_s = digits_r;
        if (!clearn) begin
            digits_nxt_s = 16'h0000;
        end else if (key_ok_s) begin
            digits_nxt_s = {digits_r[11:0], key_digit};
        end else if (tick_s) begin
            digits_nxt_s = bcd_dec(digits_r);
        end else begin
            digits_nxt_s = digits_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            digits_r <= 16'h0000;
            presc_r  <= PRESC_ZERO;
        end else begin
            digits_r <= digits_nxt_s;
            presc_r  <= presc_nxt_s;
        end
    end

    assign min_tens   = digits_r[15:12];
    assign min_units  = digits_r[11:8];
    assign sec_tens   = digits_r[7:4];
    assign sec_units  = digits_r[3:0];
    assign timer_done = (digits_r == 16'h0000);

endmodule

// File: tb/tb_nivel2_timer.sv
// Directed bench for nivel2_timer with TICK_DIV=4. Expected display
// values are pushed into a scoreboard queue as stimulus is applied and
// popped against the DUT outputs one cycle-settled step later.
module tb_nivel2_timer;

    logic       clk;
    logic       resetn;
    logic       clearn;
    logic       mag_on;
    logic       key_valid;
    logic [3:0] key_digit;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       timer_done;

    int checks;
    int errors;

    typedef struct {
        string       tag;
        logic [16:0] exp;
    } exp_t;

    exp_t sb_q[$];

    nivel2_timer #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clearn     (clearn),
        .mag_on     (mag_on),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .min_tens   (min_tens),
        .min_units  (min_units),
        .sec_tens   (sec_tens),
        .sec_units  (sec_units),
        .timer_done (timer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit later.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle keypad strobe.
    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cyc(1);
        key_valid = 1'b0;
        key_digit = 4'hx;
    endtask

    task automatic push(input string tag, input logic [15:0] digits, input logic done);
        exp_t e;
        e.tag = tag;
        e.exp = {digits, done};
        sb_q.push_back(e);
    endtask

    task automatic chk();
        exp_t        e;
        logic [16:0] obs;
        obs = {min_tens, min_units, sec_tens, sec_units, timer_done};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h, required an entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed digits=%h done=%b, expected digits=%h done=%b",
                       e.tag, obs[16:1], obs[0], e.exp[16:1], e.exp[0]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        resetn    = 1'b0;
        clearn    = 1'b1;
        mag_on    = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'h0;

        // Reset
        cyc(1);
        push("reset", 16'h0000, 1'b1); chk();
        resetn = 1'b1;
        cyc(1);

        // Keypad entry 1,3,0 -> 01:30
        key(4'd1); key(4'd3); key(4'd0);
        push("load_0130", 16'h0130, 1'b0); chk();
        key(4'd12);
        push("bad_digit_ignored", 16'h0130, 1'b0); chk();
        mag_on = 1'b1;
        key(4'd5);
        mag_on = 1'b0;
        push("key_while_running", 16'h0130, 1'b0); chk();
        cyc(1);
        push("idle_no_strobe", 16'h0130, 1'b0); chk();

        // Minute borrow: 01:00 -> 00:59 on the 4th running edge
        key(4'd0); key(4'd1); key(4'd0); key(4'd0);
        push("load_0100", 16'h0100, 1'b0); chk();
        mag_on = 1'b1;
        cyc(3);
        push("before_tick", 16'h0100, 1'b0); chk();
        cyc(1);
        mag_on = 1'b0;
        push("borrow_min", 16'h0059, 1'b0); chk();

        // Minute-tens borrow: 10:00 -> 09:59
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        push("load_1000", 16'h1000, 1'b0); chk();
        mag_on = 1'b1;
        cyc(4);
        mag_on = 1'b0;
        push("borrow_mtens", 16'h0959, 1'b0); chk();

        // 00:01 -> 00:00 with done on the tick edge
        key(4'd0); key(4'd0); key(4'd0); key(4'd1);
        push("load_0001", 16'h0001, 1'b0); chk();
        mag_on = 1'b1;
        cyc(4);
        mag_on = 1'b0;
        push("reach_zero", 16'h0000, 1'b1); chk();

        // Unnormalised seconds and seconds-tens borrow
        key(4'd7); key(4'd5);
        mag_on = 1'b1;
        cyc(4);
        mag_on = 1'b0;
        push("unnormalised_75", 16'h0074, 1'b0); chk();
        key(4'd0); key(4'd0); key(4'd1); key(4'd0);
        mag_on = 1'b1;
        cyc(4);
        mag_on = 1'b0;
        push("borrow_stens", 16'h0009, 1'b0); chk();

        // Pause discards partial second
        key(4'd0); key(4'd0); key(4'd0); key(4'd5);
        mag_on = 1'b1;
        cyc(6);
        mag_on = 1'b0;
        push("pause_run6", 16'h0004, 1'b0); chk();
        cyc(10);
        push("pause_hold", 16'h0004, 1'b0); chk();
        mag_on = 1'b1;
        cyc(3);
        push("resume_no_early_tick", 16'h0004, 1'b0); chk();
        cyc(1);
        mag_on = 1'b0;
        push("resume_tick", 16'h0003, 1'b0); chk();

        // Clear mid-count
        key(4'd0); key(4'd0); key(4'd3); key(4'd0);
        mag_on = 1'b1;
        cyc(2);
        clearn = 1'b0;
        cyc(1);
        clearn = 1'b1;
        mag_on = 1'b0;
        push("clear_midcount", 16'h0000, 1'b1); chk();
        key(4'd4);
        push("load_after_clear", 16'h0004, 1'b0); chk();
        clearn = 1'b0;
        key(4'd7);
        clearn = 1'b1;
        push("clear_beats_key", 16'h0000, 1'b1); chk();

        // Terminal hold at 00:00
        mag_on = 1'b1;
        cyc(20);
        mag_on = 1'b0;
        push("terminal_hold", 16'h0000, 1'b1); chk();

        // Reset mid-count
        key(4'd3); key(4'd0);
        mag_on = 1'b1;
        cyc(6);
        push("run_0030", 16'h0029, 1'b0); chk();
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
        mag_on = 1'b0;
        push("reset_midcount", 16'h0000, 1'b1); chk();

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
